// File: rtl/adc_wave_capture_pkg.sv
// Shared types and constants for the ADC waveform capture block:
// capture states, control/status bit positions and the status readback word.
package adc_wave_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } cap_state_e;

    typedef enum logic [1:0] {
        RD_ZERO,
        RD_RAM,
        RD_STATUS
    } rd_sel_e;

    localparam int CTL_ARM     = 0;
    localparam int CTL_FORCE   = 1;
    localparam int CTL_TRIG_EN = 2;
    localparam int CTL_ABORT   = 3;

    localparam int STS_DONE    = 15;
    localparam int STS_ARMED   = 14;
    localparam int STS_BUSY    = 13;

    localparam logic [15:0] STATUS_ADDR = 16'hFFFF;

    function automatic logic [15:0] status_word(input cap_state_e st, input logic done);
        logic [15:0] w;
        w            = '0;
        w[STS_DONE]  = done;
        w[STS_ARMED] = (st == ST_ARMED);
        w[STS_BUSY]  = (st == ST_PRE) || (st == ST_POST);
        w[2:0]       = st;
        return w;
    endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old data.
module wave_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/adc_wave_capture.sv
// Circular ADC capture around a trigger, with indexed readback and a status
// word for the Nios PIOs. Readback has a fixed two-cycle latency.
module adc_wave_capture
    import adc_wave_capture_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int ADDR_W   = 10,
    parameter int PRETRIG  = 64
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic                ext_trig,
    input  logic [7:0]          adc_control,
    input  logic [15:0]         samplenum,
    output logic [SAMPLE_W-1:0] wavesample
);

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam int                CNT_W   = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  PRE_N   = CNT_W'(PRETRIG);
    localparam logic [CNT_W-1:0]  POST_N  = CNT_W'(DEPTH - PRETRIG);
    localparam logic [ADDR_W-1:0] PRE_OFS = ADDR_W'(PRETRIG);

    cap_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W-1:0]   trig_ptr_q, trig_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                pend_q, pend_d;
    logic                arm_prev_q, arm_prev_d;
    logic                force_prev_q, force_prev_d;
    logic                abort_prev_q, abort_prev_d;
    logic                ext_prev_q, ext_prev_d;
    rd_sel_e             sel_q, sel_d;
    logic [SAMPLE_W-1:0] wavesample_q, wavesample_d;

    logic                arm_edge, force_edge, abort_edge, ext_edge, trig_evt;
    logic                we;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] ram_rdata;
    logic                ctl_unused;

    assign ctl_unused = ^adc_control[7:4];

    assign arm_edge   = adc_control[CTL_ARM]   & ~arm_prev_q;
    assign force_edge = adc_control[CTL_FORCE] & ~force_prev_q;
    assign abort_edge = adc_control[CTL_ABORT] & ~abort_prev_q;
    assign ext_edge   = ext_trig & ~ext_prev_q & adc_control[CTL_TRIG_EN];
    assign trig_evt   = ext_edge | force_edge;

    always_comb begin
        state_d      = state_q;
        wptr_d       = wptr_q;
        trig_ptr_d   = trig_ptr_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        pend_d       = 1'b0;
        we           = 1'b0;
        arm_prev_d   = adc_control[CTL_ARM];
        force_prev_d = adc_control[CTL_FORCE];
        abort_prev_d = adc_control[CTL_ABORT];
        ext_prev_d   = ext_trig;

        if (abort_edge) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm_edge) begin
                        state_d = ST_PRE;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                    end
                end
                ST_PRE: begin
                    // Triggers seen here are dropped: the pre-trigger window is not full yet.
                    if (adc_valid) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + ADDR_W'(1);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == PRE_N) state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (adc_valid) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + ADDR_W'(1);
                        if (trig_evt || pend_q) begin
                            trig_ptr_d = wptr_q;
                            cnt_d      = CNT_W'(1);
                            state_d    = (POST_N == CNT_W'(1)) ? ST_DONE : ST_POST;
                            done_d     = (POST_N == CNT_W'(1));
                        end
                    end else begin
                        pend_d = pend_q | trig_evt;
                    end
                end
                ST_POST: begin
                    if (adc_valid) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + ADDR_W'(1);
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q + CNT_W'(1) == POST_N) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Readback stage 1: address into the RAM's registered port, select registered alongside.
    always_comb begin
        rd_addr = trig_ptr_q - PRE_OFS + samplenum[ADDR_W-1:0];
        if (samplenum == STATUS_ADDR)
            sel_d = RD_STATUS;
        else if ({16'd0, samplenum} < 32'(DEPTH))
            sel_d = RD_RAM;
        else
            sel_d = RD_ZERO;
    end

    always_comb begin
        wavesample_d = '0;
        unique case (sel_q)
            RD_RAM:    wavesample_d = ram_rdata;
            RD_STATUS: wavesample_d = SAMPLE_W'(status_word(state_q, done_q));
            default:   wavesample_d = '0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q      <= ST_IDLE;
            wptr_q       <= '0;
            trig_ptr_q   <= '0;
            cnt_q        <= '0;
            done_q       <= 1'b0;
            pend_q       <= 1'b0;
            arm_prev_q   <= 1'b0;
            force_prev_q <= 1'b0;
            abort_prev_q <= 1'b0;
            ext_prev_q   <= 1'b0;
            sel_q        <= RD_ZERO;
            wavesample_q <= '0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            trig_ptr_q   <= trig_ptr_d;
            cnt_q        <= cnt_d;
            done_q       <= done_d;
            pend_q       <= pend_d;
            arm_prev_q   <= arm_prev_d;
            force_prev_q <= force_prev_d;
            abort_prev_q <= abort_prev_d;
            ext_prev_q   <= ext_prev_d;
            sel_q        <= sel_d;
            wavesample_q <= wavesample_d;
        end
    end

    wave_ram #(
        .DATA_W (SAMPLE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk_clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (adc_data),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign wavesample = wavesample_q;

endmodule

// File: tb/tb_adc_wave_capture.sv
// Directed bench for adc_wave_capture: ramp captures around ext/force triggers,
// pending triggers, wraparound, abort, readback latency and reset.
module tb_adc_wave_capture;

    logic        clk_clk = 1'b0;
    logic        reset_reset;
    logic [15:0] adc_data;
    logic        adc_valid;
    logic        ext_trig;
    logic [7:0]  adc_control;
    logic [15:0] samplenum;
    logic [15:0] wavesample;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [15:0] ramp  = 16'd0;

    adc_wave_capture dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .ext_trig    (ext_trig),
        .adc_control (adc_control),
        .samplenum   (samplenum),
        .wavesample  (wavesample)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [15:0] exp);
        total++;
        assert (wavesample === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, wavesample, exp);
        end
    endtask

    // One valid ramp sample per cycle; inputs change 1 time unit after the edge.
    task automatic tick();
        adc_data  = ramp;
        adc_valid = 1'b1;
        @(posedge clk_clk);
        #1;
        ramp++;
    endtask

    task automatic idle_tick();
        adc_data  = 16'hDEAD;
        adc_valid = 1'b0;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic run_to(input int t);
        while (int'(ramp) < t) tick();
    endtask

    task automatic rd(input logic [15:0] sn, input logic [15:0] exp, input string tag);
        samplenum = sn;
        tick();
        tick();
        chk(tag, exp);
    endtask

    initial begin
        reset_reset = 1'b1;
        adc_data    = '0;
        adc_valid   = 1'b0;
        ext_trig    = 1'b0;
        adc_control = 8'h00;
        samplenum   = 16'hFFFF;
        repeat (2) @(posedge clk_clk);
        #1;
        chk("reset_wavesample", 16'h0000);
        reset_reset = 1'b0;
        rd(16'hFFFF, 16'h0000, "idle_status");

        // Ramp, arm at 0, ext edge at 200
        adc_control = 8'h04; tick();
        ramp = 0; adc_control = 8'h05;
        run_to(200);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(1170);
        rd(16'hFFFF, 16'h8004, "t2_status_done");
        rd(16'd0,    16'd136,  "t2_sn0");
        rd(16'd5,    16'd141,  "t2_sn5");
        rd(16'd64,   16'd200,  "t2_sn64_trig");
        rd(16'd500,  16'd636,  "t2_sn500");
        rd(16'd1023, 16'd1159, "t2_sn1023");

        // Trigger during PRE discarded, real trigger at 100
        adc_control = 8'h04; tick();
        ramp = 0; adc_control = 8'h05;
        run_to(10);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(20);
        rd(16'hFFFF, 16'h2001, "t3_status_pre");
        run_to(70);
        rd(16'hFFFF, 16'h4002, "t3_status_armed");
        run_to(100);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(200);
        rd(16'hFFFF, 16'h2003, "t3_status_post");
        run_to(1080);
        rd(16'hFFFF, 16'h8004, "t3_status_done");
        rd(16'd64,   16'd100,  "t3_sn64");
        rd(16'd63,   16'd99,   "t3_sn63");
        rd(16'd65,   16'd101,  "t3_sn65");

        // ext edge while adc_valid=0 is held for the next valid sample
        adc_control = 8'h04; tick();
        ramp = 0; adc_control = 8'h05;
        run_to(70);
        ext_trig = 1'b1; idle_tick(); ext_trig = 1'b0;
        idle_tick(); idle_tick();
        ramp = 57;
        run_to(1030);
        rd(16'hFFFF, 16'h8004, "t4a_status_done");
        rd(16'd64,   16'd57,   "t4a_sn64");
        rd(16'd63,   16'd69,   "t4a_sn63");
        rd(16'd65,   16'd58,   "t4a_sn65");

        // Force edge with TRIG_EN=0; ext_trig must be ignored
        adc_control = 8'h00; tick();
        ramp = 0; adc_control = 8'h01;
        run_to(66);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(70);
        rd(16'hFFFF, 16'h4002, "t4b_status_armed");
        adc_control = 8'h03; idle_tick();
        adc_control = 8'h01; idle_tick();
        ramp = 57;
        run_to(1030);
        rd(16'd64,   16'd57,   "t4b_sn64");
        rd(16'd63,   16'd71,   "t4b_sn63");

        // Wraparound: arm at 4000, trigger at 5000
        adc_control = 8'h00; tick();
        ramp = 4000; adc_control = 8'h05;
        run_to(5000);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(5970);
        rd(16'hFFFF, 16'h8004, "t5_status_done");
        rd(16'd0,    16'd4936, "t5_sn0");
        samplenum = 16'd1023;
        tick();
        chk("t5_latency_1cyc_old", 16'd4936);
        tick();
        chk("t5_latency_2cyc_new", 16'd5959);
        rd(16'd2000, 16'h0000, "t5_sn2000");
        rd(16'hFFFE, 16'h0000, "t5_snFFFE");
        rd(16'd64,   16'd5000, "t5_sn64");

        // Abort during POST, then simultaneous arm+abort
        adc_control = 8'h04; tick();
        ramp = 0; adc_control = 8'h05;
        run_to(70);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(100);
        rd(16'hFFFF, 16'h2003, "t6_status_post");
        adc_control = 8'h0D; tick();
        rd(16'hFFFF, 16'h0000, "t6_abort_idle");
        adc_control = 8'h04; tick();
        adc_control = 8'h0D; tick();
        rd(16'hFFFF, 16'h0000, "t6_arm_abort_idle");

        // Reset mid-POST
        adc_control = 8'h04; tick();
        ramp = 0; adc_control = 8'h05;
        run_to(70);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        run_to(100);
        rd(16'hFFFF, 16'h2003, "t7_status_post");
        reset_reset = 1'b1;
        tick();
        chk("t7_reset_wavesample", 16'h0000);
        reset_reset = 1'b0;
        adc_control = 8'h00;
        rd(16'hFFFF, 16'h0000, "t7_status_after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc_wave_capture.md
Name: adc_wave_capture

Overview:
- Fabric-side responder for the Nios capture path: records ADC samples into a circular buffer around a trigger.
- Serves samples back to software by index. Software drives the 16-bit sample-number PIO and the 8-bit control PIO; this block answers on the 16-bit wave-sample PIO.
- Sits between the ADC front end and the Qsys system.

Parameters:
- SAMPLE_W, 16, ADC sample and readback width.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W = 1024 samples.
- PRETRIG, 64, samples kept before the trigger; legal range 1..DEPTH-1.

Ports:
- clk_clk  in  1  system clock; all logic on its rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- adc_data  in  SAMPLE_W  ADC sample, synchronous to clk_clk.
- adc_valid  in  1  qualifies adc_data for one cycle.
- ext_trig  in  1  external trigger level, synchronous to clk_clk.
- adc_control  in  8  from control PIO. Bit0 arm, bit1 force trigger, bit2 trigger enable for ext_trig, bit3 abort, bits 7:4 ignored.
- samplenum  in  16  from sample-number PIO; readback index.
- wavesample  out  SAMPLE_W  to wave-sample PIO; sample data or status word.

Behaviour:
- Reset: wavesample=0, state IDLE, write pointer 0, done 0, all edge-detect registers 0.
- Control bits 0, 1 and 3 act on rising edge only (previous value registered). Software writes levels.
- ext_trig acts on rising edge, and only when adc_control[2]=1.
- Trigger event = ext_trig edge OR force edge. An event arriving while adc_valid=0 is held pending and consumed by the next valid sample.
- States:
  - IDLE: nothing written. Arm edge -> PRE, pre counter cleared.
  - PRE: each valid sample is written at wptr, wptr++ mod DEPTH, pre counter++. Trigger events are discarded and not held pending. When PRETRIG samples are written -> ARMED.
  - ARMED: valid samples keep being written circularly. The first valid sample with a trigger (direct or pending) is the trigger sample: trig_ptr latched to its address, post counter=1 -> POST.
  - POST: valid samples written; when the post counter reaches DEPTH-PRETRIG, including the trigger sample -> DONE, done=1.
  - DONE: no writes. Arm edge -> PRE, done=0.
- Abort edge in any state -> IDLE, done=0, pending trigger cleared. Abort beats arm when both edges occur in the same cycle.
- Arm edges in PRE, ARMED or POST are ignored.
- Readback:
  - samplenum in 0..DEPTH-1 reads RAM at (trig_ptr - PRETRIG + samplenum) mod DEPTH, ADDR_W-bit wraparound, so samplenum PRETRIG returns the trigger sample.
  - samplenum = 0xFFFF returns status: [15] done, [14] state==ARMED, [13] state in {PRE, POST}, [12:3] 0, [2:0] state code (IDLE 0, PRE 1, ARMED 2, POST 3, DONE 4).
  - Any other samplenum returns 0x0000.
- Read latency is 2 cycles: samplenum and select registered, then synchronous RAM or status mux registered to wavesample.
- Reads outside DONE return current RAM content with no consistency guarantee.
- Same-address read and write in one cycle returns the old data.
- wavesample holds its last value between samplenum changes. After reset it stays 0 until the first registered read.

Decomposition:
- Package adc_wave_capture_pkg holds:
  - state enum with the codes above;
  - control bit indices ARM=0, FORCE=1, TRIG_EN=2, ABORT=3;
  - status bit indices;
  - STATUS_ADDR = 16'hFFFF.
- One sub-module, wave_ram: simple dual-port RAM, DEPTH x SAMPLE_W, one write port, one registered read port, read-old-data on collision, inferable as block RAM.

Test Plan:
- Reset asserted mid-POST -> wavesample=0 next cycle; after release, samplenum=0xFFFF gives wavesample=0x0000 two cycles later.
- adc_data ramps 0,1,2… every cycle with valid high, TRIG_EN=1, arm at ramp 0, ext_trig edge at ramp 200 -> status 0x8004; samplenum k returns 136+k; samplenum 64 returns 200; samplenum 1023 returns 1159.
- Same ramp, ext_trig edge at ramp 10 (during PRE), then again at 100 -> samplenum 64 returns 100.
- Trigger only while adc_valid=0, next valid sample 57 (in ARMED) -> samplenum 64 returns 57. Force edge with TRIG_EN=0 behaves the same.
- Arm at ramp 4000, trigger at 5000 (write wraps several times) -> samplenum 0 returns 4936; 1023 returns 5959.
- Abort edge during POST -> status 0x0000. Arm and abort in the same cycle -> stays IDLE. samplenum 2000 -> 0x0000. A samplenum change to a new value shows on wavesample exactly 2 cycles later.
